// File: rtl/exe_pkg.sv
// Shared opcode, forwarding-select and flag definitions for the execute stage.
package exe_pkg;

   localparam logic [4:0] OP_AND = 5'd0;
   localparam logic [4:0] OP_EOR = 5'd1;
   localparam logic [4:0] OP_LSL = 5'd2;
   localparam logic [4:0] OP_LSR = 5'd3;
   localparam logic [4:0] OP_ASR = 5'd4;
   localparam logic [4:0] OP_ADC = 5'd5;
   localparam logic [4:0] OP_SBC = 5'd6;
   localparam logic [4:0] OP_ROR = 5'd7;
   localparam logic [4:0] OP_TST = 5'd8;
   localparam logic [4:0] OP_NEG = 5'd9;
   localparam logic [4:0] OP_CMP = 5'd10;
   localparam logic [4:0] OP_CMN = 5'd11;
   localparam logic [4:0] OP_ORR = 5'd12;
   localparam logic [4:0] OP_MUL = 5'd13;
   localparam logic [4:0] OP_BIC = 5'd14;
   localparam logic [4:0] OP_MVN = 5'd15;
   localparam logic [4:0] OP_ADD = 5'd16;
   localparam logic [4:0] OP_SUB = 5'd17;
   localparam logic [4:0] OP_MOV = 5'd18;
   localparam logic [4:0] OP_NOP = 5'd19;

   localparam logic [3:0] FWD_NONE = 4'd0;
   localparam logic [3:0] FWD_E1   = 4'd1;
   localparam logic [3:0] FWD_E2   = 4'd2;
   localparam logic [3:0] FWD_M    = 4'd4;

   typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shift_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;

   // Unrecognised select codes (including FWD_NONE) fall back to the raw operand.
   function automatic logic [31:0] fwd_sel(input logic [3:0] hz, input logic [31:0] raw,
                                           input logic [31:0] e1, input logic [31:0] e2,
                                           input logic [31:0] m);
      case (hz)
         FWD_E1:  fwd_sel = e1;
         FWD_E2:  fwd_sel = e2;
         FWD_M:   fwd_sel = m;
         default: fwd_sel = raw;
      endcase
   endfunction

endpackage

// File: rtl/exe_v2_if.sv
// Execute-stage operand/result bundle; master drives operands, slave returns results.
interface exe_v2_if;
   logic [31:0] X;
   logic [31:0] Y;
   logic [3:0]  RD_IN;
   logic [7:0]  SHAMT;
   logic [4:0]  OPTYPE;
   logic        XY_SEL;
   logic        VALIDRD_IN;
   logic [3:0]  NZCV;
   logic [31:0] EXE_DF1;
   logic [31:0] EXE_DF2;
   logic [31:0] MEM_DF;
   logic [3:0]  HZ_CTRLX;
   logic [3:0]  HZ_CTRLY;
   logic [31:0] Z_RESULT;
   logic [3:0]  RD_OUT;
   logic [3:0]  NZCVUPDATE;
   logic        VALIDRD_OUT;

   modport master (
      output X, Y, RD_IN, SHAMT, OPTYPE, XY_SEL, VALIDRD_IN, NZCV,
             EXE_DF1, EXE_DF2, MEM_DF, HZ_CTRLX, HZ_CTRLY,
      input  Z_RESULT, RD_OUT, NZCVUPDATE, VALIDRD_OUT
   );

   modport slave (
      input  X, Y, RD_IN, SHAMT, OPTYPE, XY_SEL, VALIDRD_IN, NZCV,
             EXE_DF1, EXE_DF2, MEM_DF, HZ_CTRLX, HZ_CTRLY,
      output Z_RESULT, RD_OUT, NZCVUPDATE, VALIDRD_OUT
   );
endinterface

// File: rtl/exe_shifter.sv
// ARM-style barrel shifter (LSL/LSR/ASR/ROR) with carry-out.
// Latency: combinational, zero cycles.
// Backpressure: none; no handshake.
module exe_shifter
   import exe_pkg::*;
(
   input  logic [31:0] value,
   input  shift_t      sh_type,
   input  logic [7:0]  amount,
   input  logic        c_in,
   output logic [31:0] result,
   output logic        c_out
);

   logic [32:0] ext;
   logic [4:0]  rot;

   // The 33-bit extension carries the last bit shifted out alongside the result.
   always_comb begin
      ext    = '0;
      rot    = amount[4:0];
      result = value;
      c_out  = c_in;
      if (amount != 8'd0) begin
         case (sh_type)
            SH_LSL: begin
               ext = {1'b0, value} << amount;
               if (amount > 8'd32) begin
                  result = '0;
                  c_out  = 1'b0;
               end else begin
                  result = ext[31:0];
                  c_out  = ext[32];
               end
            end
            SH_LSR: begin
               ext = {value, 1'b0} >> amount;
               if (amount > 8'd32) begin
                  result = '0;
                  c_out  = 1'b0;
               end else begin
                  result = ext[32:1];
                  c_out  = ext[0];
               end
            end
            SH_ASR: begin
               ext = 33'($signed({value, 1'b0}) >>> amount);
               if (amount >= 8'd32) begin
                  result = {32{value[31]}};
                  c_out  = value[31];
               end else begin
                  result = ext[32:1];
                  c_out  = ext[0];
               end
            end
            SH_ROR: begin
               if (rot == 5'd0) begin
                  result = value;
                  c_out  = value[31];
               end else begin
                  result = (value >> rot) | (value << (6'd32 - {1'b0, rot}));
                  c_out  = result[31];
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/exe_v2.sv
// Execute stage: operand forwarding, ALU/shift/multiply, NZCV update.
// Latency: combinational, zero cycles (only rst_done is registered).
// Backpressure: none; no handshake.
module exe_v2
   import exe_pkg::*;
(
   input  logic    CLK,
   input  logic    RESET_N,
   exe_v2_if.slave bus
);

   logic        rst_done;
   logic [31:0] xr;
   logic [31:0] yr;
   logic [31:0] sh_src;
   logic [31:0] sh_res;
   logic        sh_c;
   shift_t      sh_type;
   logic [31:0] a_op;
   logic [31:0] b_op;
   logic        cin;
   logic [32:0] sum;
   logic        v_add;
   logic [31:0] res;
   logic        no_wb;
   nzcv_t       fin;
   nzcv_t       fout;

   always_ff @(posedge CLK) begin
      if (!RESET_N) rst_done <= 1'b0;
      else          rst_done <= 1'b1;
   end

   assign xr     = fwd_sel(bus.HZ_CTRLX, bus.X, bus.EXE_DF1, bus.EXE_DF2, bus.MEM_DF);
   assign yr     = fwd_sel(bus.HZ_CTRLY, bus.Y, bus.EXE_DF1, bus.EXE_DF2, bus.MEM_DF);
   assign sh_src = bus.XY_SEL ? yr : xr;
   assign fin    = bus.NZCV;

   always_comb begin
      case (bus.OPTYPE)
         OP_LSR:  sh_type = SH_LSR;
         OP_ASR:  sh_type = SH_ASR;
         OP_ROR:  sh_type = SH_ROR;
         default: sh_type = SH_LSL;
      endcase
   end

   exe_shifter u_shifter (
      .value   (sh_src),
      .sh_type (sh_type),
      .amount  (bus.SHAMT),
      .c_in    (fin.c),
      .result  (sh_res),
      .c_out   (sh_c)
   );

   // Subtraction is a + ~b + cin so the carry out is directly NOT borrow.
   always_comb begin
      a_op = xr;
      b_op = yr;
      cin  = 1'b0;
      case (bus.OPTYPE)
         OP_ADC:         cin = fin.c;
         OP_SUB, OP_CMP: begin b_op = ~yr; cin = 1'b1;  end
         OP_SBC:         begin b_op = ~yr; cin = fin.c; end
         OP_NEG:         begin a_op = '0; b_op = ~yr; cin = 1'b1; end
         default:        ;
      endcase
      sum   = {1'b0, a_op} + {1'b0, b_op} + {32'd0, cin};
      v_add = (a_op[31] == b_op[31]) && (sum[31] != a_op[31]);
   end

   always_comb begin
      res   = xr;
      fout  = fin;
      no_wb = 1'b0;
      case (bus.OPTYPE)
         OP_AND: res = xr & yr;
         OP_EOR: res = xr ^ yr;
         OP_TST: begin res = xr & yr; no_wb = 1'b1; end
         OP_ORR: res = xr | yr;
         OP_MUL: res = xr * yr;
         OP_BIC: res = xr & ~yr;
         OP_MVN: res = ~yr;
         OP_MOV: res = yr;
         OP_LSL, OP_LSR, OP_ASR, OP_ROR: begin
            res    = sh_res;
            fout.c = sh_c;
         end
         OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_NEG, OP_CMP, OP_CMN: begin
            res    = sum[31:0];
            fout.c = sum[32];
            fout.v = v_add;
            no_wb  = (bus.OPTYPE == OP_CMP) || (bus.OPTYPE == OP_CMN);
         end
         default: res = xr;
      endcase
      if (bus.OPTYPE < OP_NOP) begin
         fout.n = res[31];
         fout.z = (res == 32'd0);
      end
      if (!rst_done) fout = fin;
   end

   assign bus.Z_RESULT    = res;
   assign bus.RD_OUT      = bus.RD_IN;
   assign bus.NZCVUPDATE  = fout;
   assign bus.VALIDRD_OUT = bus.VALIDRD_IN & rst_done & ~no_wb;

endmodule

// File: tb/tb_exe_v2.sv
// Directed bench for exe_v2: expected results queued at drive time, popped at the check point.
module tb_exe_v2;
   import exe_pkg::*;

   typedef struct {
      string       tag;
      logic [31:0] z;
      logic [3:0]  f;
      logic        v;
      logic [3:0]  rd;
   } exp_t;

   logic     clk;
   logic     rst_n;
   exe_v2_if bus ();
   exp_t     exp_q[$];
   int       vectors;
   int       miscompares;
   logic     vin;
   logic [3:0] rd_cnt;

   exe_v2 dut (.CLK(clk), .RESET_N(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic go(input string tag, input logic [4:0] op, input logic [31:0] x,
                     input logic [31:0] y, input logic [7:0] sh, input logic xs,
                     input logic [3:0] f, input logic [31:0] ez, input logic [3:0] ef,
                     input logic ev);
      exp_t e;
      rd_cnt         = rd_cnt + 4'd1;
      bus.OPTYPE     = op;
      bus.X          = x;
      bus.Y          = y;
      bus.SHAMT      = sh;
      bus.XY_SEL     = xs;
      bus.NZCV       = f;
      bus.VALIDRD_IN = vin;
      bus.RD_IN      = rd_cnt;
      exp_q.push_back('{tag, ez, ef, ev, rd_cnt});
      @(negedge clk);
      e = exp_q.pop_front();
      chk({e.tag, ".z"},   bus.Z_RESULT,           e.z);
      chk({e.tag, ".f"},   {28'd0, bus.NZCVUPDATE}, {28'd0, e.f});
      chk({e.tag, ".vld"}, {31'd0, bus.VALIDRD_OUT}, {31'd0, e.v});
      chk({e.tag, ".rd"},  {28'd0, bus.RD_OUT},     {28'd0, e.rd});
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      vin         = 1'b1;
      rd_cnt      = 4'd0;
      bus.EXE_DF1  = 32'hA5A5_0001;
      bus.EXE_DF2  = 32'hA5A5_0002;
      bus.MEM_DF   = 32'hA5A5_0004;
      bus.HZ_CTRLX = FWD_NONE;
      bus.HZ_CTRLY = FWD_NONE;
      bus.OPTYPE = OP_ADD; bus.X = 32'd1; bus.Y = 32'd2; bus.SHAMT = 8'd0;
      bus.XY_SEL = 1'b0; bus.NZCV = 4'b1010; bus.VALIDRD_IN = 1'b1; bus.RD_IN = 4'd0;

      // Power-up reset: two edges low, then release.
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      go("rst_hold",  OP_ADD, 32'd1, 32'd2, 8'd0, 1'b0, 4'b1010, 32'd3, 4'b1010, 1'b0);
      rst_n = 1'b1;
      go("rst_rel",   OP_ADD, 32'd1, 32'd2, 8'd0, 1'b0, 4'b1010, 32'd3, 4'b1010, 1'b0);
      go("rst_done",  OP_ADD, 32'd1, 32'd2, 8'd0, 1'b0, 4'b1010, 32'd3, 4'b0000, 1'b1);

      go("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 8'd0, 1'b0, 4'b0000, 32'h8000_0000, 4'b1001, 1'b1);
      go("cmp_eq",  OP_CMP, 32'd5, 32'd5, 8'd0, 1'b0, 4'b0000, 32'd0, 4'b0110, 1'b0);
      go("lsl32",   OP_LSL, 32'd1, 32'd0, 8'd32, 1'b0, 4'b0000, 32'd0, 4'b0110, 1'b1);
      go("lsl0",    OP_LSL, 32'd1, 32'd0, 8'd0, 1'b0, 4'b0010, 32'd1, 4'b0010, 1'b1);
      bus.HZ_CTRLX = 4'd2; bus.EXE_DF2 = 32'h10;
      go("fwd_e2",  OP_ADD, 32'hFFFF, 32'h20, 8'd0, 1'b0, 4'b0000, 32'h30, 4'b0000, 1'b1);
      bus.HZ_CTRLX = 4'd7;
      go("fwd_raw", OP_ADD, 32'hFFFF, 32'h20, 8'd0, 1'b0, 4'b0000, 32'h1001F, 4'b0000, 1'b1);
      bus.HZ_CTRLX = FWD_NONE;
      go("asr40",   OP_ASR, 32'h8000_0000, 32'd0, 8'd40, 1'b0, 4'b0000, 32'hFFFF_FFFF, 4'b1010, 1'b1);
      go("sub_neg", OP_SUB, 32'd3, 32'd5, 8'd0, 1'b0, 4'b0000, 32'hFFFF_FFFE, 4'b1000, 1'b1);
      go("sbc",     OP_SBC, 32'd10, 32'd3, 8'd0, 1'b0, 4'b0000, 32'd6, 4'b0010, 1'b1);
      go("adc",     OP_ADC, 32'hFFFF_FFFF, 32'd0, 8'd0, 1'b0, 4'b0010, 32'd0, 4'b0110, 1'b1);
      go("mul",     OP_MUL, 32'h1_0000, 32'h1_0001, 8'd0, 1'b0, 4'b0011, 32'h1_0000, 4'b0011, 1'b1);
      go("lsr32y",  OP_LSR, 32'd1, 32'h8000_0000, 8'd32, 1'b1, 4'b0001, 32'd0, 4'b0111, 1'b1);
      go("ror32",   OP_ROR, 32'h8000_0001, 32'd0, 8'd32, 1'b0, 4'b0000, 32'h8000_0001, 4'b1010, 1'b1);
      go("ror1",    OP_ROR, 32'd3, 32'd0, 8'd1, 1'b0, 4'b0000, 32'h8000_0001, 4'b1010, 1'b1);
      go("nop",     OP_NOP, 32'h1234, 32'd0, 8'd0, 1'b0, 4'b0101, 32'h1234, 4'b0101, 1'b1);
      go("op25",    5'd25, 32'h1234, 32'd0, 8'd0, 1'b0, 4'b0101, 32'h1234, 4'b0101, 1'b1);
      go("tst",     OP_TST, 32'hF0, 32'h0F, 8'd0, 1'b0, 4'b0011, 32'd0, 4'b0111, 1'b0);
      go("neg",     OP_NEG, 32'h55, 32'd1, 8'd0, 1'b0, 4'b0000, 32'hFFFF_FFFF, 4'b1000, 1'b1);
      go("cmn",     OP_CMN, 32'hFFFF_FFFF, 32'd1, 8'd0, 1'b0, 4'b0000, 32'd0, 4'b0110, 1'b0);
      bus.HZ_CTRLY = FWD_M; bus.MEM_DF = 32'h5;
      go("fwd_m",   OP_ORR, 32'h10, 32'h999, 8'd0, 1'b0, 4'b0000, 32'h15, 4'b0000, 1'b1);
      bus.HZ_CTRLY = FWD_E1; bus.EXE_DF1 = 32'h100;
      go("fwd_e1",  OP_EOR, 32'h100, 32'h7, 8'd0, 1'b0, 4'b0000, 32'd0, 4'b0100, 1'b1);
      bus.HZ_CTRLY = FWD_NONE;
      go("lsl33",   OP_LSL, 32'd1, 32'd0, 8'd33, 1'b0, 4'b0010, 32'd0, 4'b0100, 1'b1);
      go("lsl1",    OP_LSL, 32'hC000_0000, 32'd0, 8'd1, 1'b0, 4'b0000, 32'h8000_0000, 4'b1010, 1'b1);
      go("mvn",     OP_MVN, 32'd0, 32'd0, 8'd0, 1'b0, 4'b0000, 32'hFFFF_FFFF, 4'b1000, 1'b1);
      go("bic",     OP_BIC, 32'hFF, 32'h0F, 8'd0, 1'b0, 4'b0000, 32'hF0, 4'b0000, 1'b1);
      go("mov",     OP_MOV, 32'd5, 32'd0, 8'd0, 1'b0, 4'b0000, 32'd0, 4'b0100, 1'b1);
      go("and",     OP_AND, 32'hF0F0, 32'hFF00, 8'd0, 1'b0, 4'b0000, 32'hF000, 4'b0000, 1'b1);
      go("lsr1",    OP_LSR, 32'h8000_0000, 32'd0, 8'd1, 1'b0, 4'b0000, 32'h4000_0000, 4'b0000, 1'b1);
      go("asr3",    OP_ASR, 32'h8000_0004, 32'd0, 8'd3, 1'b0, 4'b0000, 32'hF000_0000, 4'b1010, 1'b1);
      vin = 1'b0;
      go("novld",   OP_ADD, 32'd1, 32'd1, 8'd0, 1'b0, 4'b0000, 32'd2, 4'b0000, 1'b0);
      vin = 1'b1;

      // Reset raised mid-operation only bites at the following rising edge.
      rst_n = 1'b0;
      go("mid_pre",  OP_ADD, 32'd1, 32'd2, 8'd0, 1'b0, 4'b1100, 32'd3, 4'b0000, 1'b1);
      go("mid_rst",  OP_ADD, 32'd1, 32'd2, 8'd0, 1'b0, 4'b1100, 32'd3, 4'b1100, 1'b0);
      rst_n = 1'b1;
      go("mid_rel",  OP_ADD, 32'd1, 32'd2, 8'd0, 1'b0, 4'b1100, 32'd3, 4'b1100, 1'b0);
      go("mid_done", OP_ADD, 32'd1, 32'd2, 8'd0, 1'b0, 4'b1100, 32'd3, 4'b0000, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
